fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage of the single-issue RV32I pipeline. Owns the PC,
//   drives the combinational instruction memory address, and captures the
//   returned word into the IF/ID pipeline register consumed by decode.
//   Handles stall (hold), redirect (branch/jump target plus bubble insertion)
//   and flags malformed fetches.
// PARAMETERS
//   RESET_PC   32'h0000_0000  PC value loaded on reset
//   NOP_INSTR  32'h0000_0013  bubble word (addi x0,x0,0) placed in IF/ID
//   CNT_W      32             width of retired-fetch counter
// PORTS
//   clk                input   1      rising-edge clock
//   rst_n              input   1      reset, asynchronous, active-low
//   stall_i            input   1      hold PC and IF/ID this cycle
//   redirect_i         input   1      take redirect_target_i, flush IF/ID
//   redirect_target_i  input   32     new PC (branch/jump target)
//   imem_addr_o        output  32     byte address to instruction memory
//   imem_instr_i       input   32     word returned by memory, same cycle
//   if_id_valid_o      output  1      IF/ID holds a real instruction
//   if_id_pc_o         output  32     PC of the instruction in IF/ID
//   if_id_pc_plus4_o   output  32     if_id_pc_o + 4
//   if_id_instr_o      output  32     instruction in IF/ID
//   if_id_illegal_o    output  1      IF/ID word has opcode[1:0] != 2'b11
//   misalign_err_o     output  1      sticky: redirect target not word-aligned
//   fetch_count_o      output  CNT_W  count of instructions accepted into IF/ID
// BEHAVIOUR
// - Reset (rst_n=0, async, no clk needed): pc=RESET_PC; if_id_valid_o=0;
//   if_id_instr_o=NOP_INSTR; if_id_pc_o=0; if_id_pc_plus4_o=0;
//   if_id_illegal_o=0; misalign_err_o=0; fetch_count_o=0.
// - imem_addr_o = pc, purely combinational; memory is zero-latency so
//   imem_instr_i is sampled at the same rising edge. Fetch latency: 1 cycle.
// - Per rising edge, priority redirect > stall > advance:
//   * redirect_i=1: pc <= {redirect_target_i[31:2],2'b00}; IF/ID <= bubble
//     (valid=0, instr=NOP_INSTR, illegal=0, pc fields=0); fetch_count holds.
//     If redirect_target_i[1:0]!=0, misalign_err_o <= 1 (sticky to reset).
//     redirect_i wins even when stall_i=1 in the same cycle.
//   * stall_i=1 (no redirect): pc, all IF/ID fields, fetch_count hold.
//   * otherwise: IF/ID <= {valid=1, pc, pc+4, imem_instr_i,
//     illegal=(imem_instr_i[1:0]!=2'b11)}; pc <= pc+4; fetch_count += 1.
// - Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000);
//   fetch_count wraps modulo 2^CNT_W.
// - Out-of-range fetch: memory returns 32'h0; stage captures it with
//   valid=1, illegal=1; no other special action (decode traps).
// - Reset asserted mid-operation: all state returns to reset values
//   immediately; first edge after release fetches RESET_PC.
// - pc[1:0] is always 2'b00; the stage never issues an unaligned address.
// TESTING
// - Reset release, no stall, memory words W0..W3 at 0x0..0xC -> after 4 edges
//   IF/ID shows pc 0x0,0x4,0x8,0xC with W0..W3, valid=1, fetch_count_o=4.
// - stall_i=1 for 3 cycles at pc=0x8 -> imem_addr_o stays 0x8, IF/ID stays
//   pc 0x4, fetch_count_o unchanged; release -> pc 0x8 captured next edge.
// - redirect_i=1, target 0x40 with stall_i=1 -> next cycle imem_addr_o=0x40,
//   if_id_valid_o=0, if_id_instr_o=0x00000013, misalign_err_o=0.
// - redirect target 0x42 -> imem_addr_o=0x40, misalign_err_o=1 and stays 1
//   through later aligned redirects until rst_n=0.
// - pc=0x3FC then fetch at 0x400 (beyond 256-word memory) -> IF/ID instr
//   0x00000000, valid=1, if_id_illegal_o=1; RESET_PC=0xFFFFFFFC -> wraps to 0x0.
// - rst_n pulsed low between edges mid-stream -> outputs at reset values
//   without a clock edge; first edge after release captures word at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address, registers IF/ID.
// Latency: 1 cycle from imem_addr_o to the IF/ID register; memory is zero-latency (same-edge sample).
// Backpressure: stall_i holds PC, IF/ID and count; redirect_i overrides stall and inserts a bubble.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   stall_i             hold PC, IF/ID and fetch count this cycle
//   redirect_i          load redirect_target_i (word-aligned) into PC, bubble IF/ID
//   redirect_target_i   branch/jump target
//   imem_addr_o         combinational byte address (always the current PC)
//   imem_instr_i        word returned by memory in the same cycle
//   if_id_*_o           IF/ID register contents consumed by decode
//   misalign_err_o      sticky flag: some redirect target had nonzero low bits
//   fetch_count_o       number of instructions accepted into IF/ID (wraps)
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [31:0]      redirect_target_i,
    output logic [31:0]      imem_addr_o,
    input  logic [31:0]      imem_instr_i,
    output logic             if_id_valid_o,
    output logic [31:0]      if_id_pc_o,
    output logic [31:0]      if_id_pc_plus4_o,
    output logic [31:0]      if_id_instr_o,
    output logic             if_id_illegal_o,
    output logic             misalign_err_o,
    output logic [CNT_W-1:0] fetch_count_o
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;

    // Natural 32-bit wrap: 0xFFFF_FFFC + 4 -> 0x0000_0000.
    assign pc_plus4    = pc + 32'd4;
    assign imem_addr_o = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc               <= RESET_PC;
            if_id_valid_o    <= 1'b0;
            if_id_pc_o       <= 32'h0;
            if_id_pc_plus4_o <= 32'h0;
            if_id_instr_o    <= NOP_INSTR;
            if_id_illegal_o  <= 1'b0;
            misalign_err_o   <= 1'b0;
            fetch_count_o    <= '0;
        end else if (redirect_i) begin
            // Low target bits are dropped so the stage never issues an unaligned
            // address; the error flag records that it happened.
            pc               <= {redirect_target_i[31:2], 2'b00};
            if_id_valid_o    <= 1'b0;
            if_id_pc_o       <= 32'h0;
            if_id_pc_plus4_o <= 32'h0;
            if_id_instr_o    <= NOP_INSTR;
            if_id_illegal_o  <= 1'b0;
            if (redirect_target_i[1:0] != 2'b00) begin
                misalign_err_o <= 1'b1;
            end
        end else if (!stall_i) begin
            pc               <= pc_plus4;
            if_id_valid_o    <= 1'b1;
            if_id_pc_o       <= pc;
            if_id_pc_plus4_o <= pc_plus4;
            if_id_instr_o    <= imem_instr_i;
            // RV32I encodings all have opcode[1:0] = 2'b11; anything else
            // (including the all-zero out-of-range word) is flagged for decode.
            if_id_illegal_o  <= (imem_instr_i[1:0] != 2'b11);
            fetch_count_o    <= fetch_count_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: scoreboard of expected IF/ID snapshots.
// Latency: expectations pushed when a cycle is driven, popped one edge later.
// Backpressure: stall/redirect patterns are applied directly.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic        if_id_illegal;
    logic        misalign_err;
    logic [31:0] fetch_count;

    // Second instance exercises PC wrap from the top of the address space.
    logic [31:0] w_addr;
    logic [31:0] w_instr;
    logic        w_valid;
    logic [31:0] w_pc;
    logic [31:0] w_pc4;
    logic [31:0] w_ins;
    logic        w_ill;
    logic        w_mis;
    logic [31:0] w_cnt;

    logic [31:0] mem [256];

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        ill;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    // Bench-side model state
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_ifpc;
    logic [31:0] m_pc4;
    logic [31:0] m_instr;
    logic        m_ill;
    logic        m_mis;
    logic [31:0] m_cnt;

    fetch_stage u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall_i           (stall),
        .redirect_i        (redirect),
        .redirect_target_i (target),
        .imem_addr_o       (imem_addr),
        .imem_instr_i      (imem_instr),
        .if_id_valid_o     (if_id_valid),
        .if_id_pc_o        (if_id_pc),
        .if_id_pc_plus4_o  (if_id_pc_plus4),
        .if_id_instr_o     (if_id_instr),
        .if_id_illegal_o   (if_id_illegal),
        .misalign_err_o    (misalign_err),
        .fetch_count_o     (fetch_count)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall_i           (1'b0),
        .redirect_i        (1'b0),
        .redirect_target_i (32'h0),
        .imem_addr_o       (w_addr),
        .imem_instr_i      (w_instr),
        .if_id_valid_o     (w_valid),
        .if_id_pc_o        (w_pc),
        .if_id_pc_plus4_o  (w_pc4),
        .if_id_instr_o     (w_ins),
        .if_id_illegal_o   (w_ill),
        .misalign_err_o    (w_mis),
        .fetch_count_o     (w_cnt)
    );

    // 256-word memory at 0x000..0x3FC; anything beyond reads as zero.
    assign imem_instr = (imem_addr < 32'h400) ? mem[imem_addr[9:2]] : 32'h0;
    assign w_instr    = (w_addr    < 32'h400) ? mem[w_addr[9:2]]    : 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a < 32'h400) ? mem[a[9:2]] : 32'h0;
    endfunction

    task automatic model_reset();
        m_pc    = 32'h0;
        m_valid = 1'b0;
        m_ifpc  = 32'h0;
        m_pc4   = 32'h0;
        m_instr = NOP;
        m_ill   = 1'b0;
        m_mis   = 1'b0;
        m_cnt   = 32'h0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".addr"},  imem_addr,             32'h0);
        check({tag, ".valid"}, {31'h0, if_id_valid},  32'h0);
        check({tag, ".pc"},    if_id_pc,              32'h0);
        check({tag, ".pc4"},   if_id_pc_plus4,        32'h0);
        check({tag, ".instr"}, if_id_instr,           NOP);
        check({tag, ".ill"},   {31'h0, if_id_illegal}, 32'h0);
        check({tag, ".mis"},   {31'h0, misalign_err}, 32'h0);
        check({tag, ".cnt"},   fetch_count,           32'h0);
    endtask

    // Drive one cycle, push the expected post-edge snapshot, then pop and compare.
    task automatic step(input string tag, input logic st, input logic rd, input logic [31:0] tgt);
        exp_t e;
        stall    = st;
        redirect = rd;
        target   = tgt;
        if (rd) begin
            m_valid = 1'b0;
            m_ifpc  = 32'h0;
            m_pc4   = 32'h0;
            m_instr = NOP;
            m_ill   = 1'b0;
            if (tgt[1:0] != 2'b00) m_mis = 1'b1;
            m_pc    = {tgt[31:2], 2'b00};
        end else if (!st) begin
            m_valid = 1'b1;
            m_ifpc  = m_pc;
            m_pc4   = m_pc + 32'd4;
            m_instr = mem_model(m_pc);
            m_ill   = (m_instr[1:0] != 2'b11);
            m_pc    = m_pc + 32'd4;
            m_cnt   = m_cnt + 32'd1;
        end
        e.addr  = m_pc;
        e.valid = m_valid;
        e.pc    = m_ifpc;
        e.pc4   = m_pc4;
        e.instr = m_instr;
        e.ill   = m_ill;
        e.mis   = m_mis;
        e.cnt   = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".addr"},  imem_addr,              e.addr);
        check({tag, ".valid"}, {31'h0, if_id_valid},   {31'h0, e.valid});
        check({tag, ".pc"},    if_id_pc,               e.pc);
        check({tag, ".pc4"},   if_id_pc_plus4,         e.pc4);
        check({tag, ".instr"}, if_id_instr,            e.instr);
        check({tag, ".ill"},   {31'h0, if_id_illegal}, {31'h0, e.ill});
        check({tag, ".mis"},   {31'h0, misalign_err},  {31'h0, e.mis});
        check({tag, ".cnt"},   fetch_count,            e.cnt);
    endtask

    initial begin
        rst_n    = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        target   = 32'h0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
        end
        mem[0] = 32'h0000_0093;
        mem[1] = 32'h0010_0113;
        mem[2] = 32'h0020_0193;
        mem[3] = 32'h0030_0212;   // opcode[1:0]=10 -> illegal
        model_reset();

        #12;
        check_reset_outputs("reset");
        check("wrap.reset_addr", w_addr, 32'hFFFF_FFFC);
        rst_n = 1'b1;

        // Straight-line fetch of W0..W3
        step("seq0", 1'b0, 1'b0, 32'h0);
        check("wrap.pc",     w_pc,            32'hFFFF_FFFC);
        check("wrap.pc4",    w_pc4,           32'h0);
        check("wrap.addr",   w_addr,          32'h0);
        check("wrap.instr",  w_ins,           32'h0);
        check("wrap.ill",    {31'h0, w_ill},  32'h1);
        check("wrap.valid",  {31'h0, w_valid}, 32'h1);
        for (int i = 1; i < 4; i++) step("seq", 1'b0, 1'b0, 32'h0);
        check("seq.count4", fetch_count, 32'd4);

        // Asynchronous reset pulse between edges
        rst_n = 1'b0;
        #1;
        check_reset_outputs("arst");
        #1;
        rst_n = 1'b1;
        model_reset();
        step("post_arst", 1'b0, 1'b0, 32'h0);
        step("adv", 1'b0, 1'b0, 32'h0);   // pc=0x8, IF/ID pc 0x4

        // Stall three cycles, then release
        for (int i = 0; i < 3; i++) step("stall", 1'b1, 1'b0, 32'h0);
        step("stall_rel", 1'b0, 1'b0, 32'h0);

        // Redirect wins over stall
        step("redir_stall", 1'b1, 1'b1, 32'h40);
        step("adv40", 1'b0, 1'b0, 32'h0);
        // Misaligned target, then aligned redirects keep the sticky flag
        step("redir_mis", 1'b0, 1'b1, 32'h42);
        step("adv", 1'b0, 1'b0, 32'h0);
        step("redir_al", 1'b0, 1'b1, 32'h80);
        step("redir_al2", 1'b1, 1'b1, 32'h100);
        step("adv", 1'b0, 1'b0, 32'h0);

        // End of memory and beyond
        step("redir_3fc", 1'b0, 1'b1, 32'h3FC);
        step("fetch_3fc", 1'b0, 1'b0, 32'h0);
        step("fetch_400", 1'b0, 1'b0, 32'h0);
        check("oor.ill", {31'h0, if_id_illegal}, 32'h1);

        // Randomised mix of stall / redirect / advance
        for (int i = 0; i < 60; i++) begin
            step("rand",
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0),
                 32'($urandom_range(0, 32'h480)));
        end

        // Reset clears the sticky error
        step("redir_mis2", 1'b0, 1'b1, 32'h11);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("arst2");
        #1;
        rst_n = 1'b1;
        model_reset();
        step("post_arst2", 1'b0, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
